mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the single-cycle ALU in the EX stage of the pipelined datapath and executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles. While busy it raises a stall request, which the hazard logic uses to hold PC, IF_ID and ID_EX. Results stay in HI/LO until the next completed operation.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mul_div_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and op-decode helpers for the multi-cycle multiply/divide unit.
// Imported by mul_div_unit and by any controller/EX-stage logic that decodes
// MDU operations.
package mdu_pkg;

  // Operation select as carried on the op port.
  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  // True for DIV and DIVU.
  function automatic logic op_is_div(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // True for the two's-complement operations MULT and DIV.
  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) on operand
// magnitudes over WIDTH cycles, then applies sign correction in a FIX cycle.
// Latency from start to done is WIDTH+2 cycles (2 for divide by zero).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, op, a, b operation request and operands, sampled only in IDLE
//   flush           abort an in-flight operation / drop a same-cycle start
//   busy            operation in progress (stall request), registered
//   done            one-cycle pulse when hi/lo/div_zero were updated
//   hi, lo          product upper/lower half, or remainder/quotient
//   div_zero        last completed divide had a zero divisor
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  // Sequencer and operation context
  mdu_state_t       state;
  logic             is_div_q;
  logic             neg_res_q;   // negate product / quotient
  logic             neg_rem_q;   // negate remainder (dividend was negative)
  logic             dz_q;        // divide by zero short-cut
  logic [CNT_W-1:0] cnt_q;

  // Datapath: acc = running high half / partial remainder,
  // mq = multiplier being consumed / dividend shifting into quotient,
  // opnd = multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] opnd_q;

  // Request decode
  mdu_op_t          op_sel;
  logic             sgn_op;
  logic             div_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Iteration step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shl;
  logic [WIDTH:0]   div_dif;
  logic             div_ok;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_mq;

  // Sign fix-up
  logic [PW-1:0]    prod_mag;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Decode the request and form operand magnitudes
  always_comb begin
    op_sel = mdu_op_t'(op);
    sgn_op = op_is_signed(op_sel);
    div_op = op_is_div(op_sel);
    a_mag  = (sgn_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag  = (sgn_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    div_shl = {acc_q, mq_q[WIDTH-1]};
    // Partial remainder is always below the divisor, so bit WIDTH of the
    // difference is a reliable borrow flag.
    div_dif = div_shl - {1'b0, opnd_q};
    div_ok  = ~div_dif[WIDTH];
    if (is_div_q) begin
      step_acc = div_ok ? div_dif[WIDTH-1:0] : div_shl[WIDTH-1:0];
      step_mq  = {mq_q[WIDTH-2:0], div_ok};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Two's-complement sign correction of the magnitude result
  always_comb begin
    prod_mag = {acc_q, mq_q};
    prod     = neg_res_q ? (~prod_mag + PW'(1)) : prod_mag;
    quo      = neg_res_q ? (~mq_q + WIDTH'(1)) : mq_q;
    rem      = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;
    if (dz_q) begin
      // mq holds the raw dividend in the zero-divisor case
      fix_hi = mq_q;
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = rem;
      fix_lo = quo;
    end else begin
      fix_hi = prod[PW-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // Sequencer, datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div_q  <= div_op;
            neg_res_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= sgn_op & a[WIDTH-1];
            acc_q     <= '0;
            cnt_q     <= CNT_W'(WIDTH - 1);
            busy      <= 1'b1;
            if (div_op && (b == '0)) begin
              dz_q   <= 1'b1;
              mq_q   <= a;
              opnd_q <= b;
              state  <= FIX;
            end else begin
              dz_q  <= 1'b0;
              state <= CALC;
              if (div_op) begin
                mq_q   <= a_mag;
                opnd_q <= b_mag;
              end else begin
                mq_q   <= b_mag;
                opnd_q <= a_mag;
              end
            end
          end
        end

        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_q <= step_acc;
            mq_q  <= step_mq;
            if (cnt_q == '0) begin
              state <= FIX;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end

        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi       <= fix_hi;
            lo       <= fix_lo;
            div_zero <= dz_q;
            done     <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (WIDTH=32).
// The driver issues operations and pushes model results with their due cycle;
// a negedge monitor pops and compares whenever done pulses.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           issue;
    int           due;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dz = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model using plain 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] mh, output logic [W-1:0] ml, output logic md);
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    md = 1'b0;
    case (o)
      2'b00: begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; mh = up[63:32]; ml = up[31:0]; end
      default: begin
        if (y == '0) begin
          mh = x; ml = '1; md = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          mh = r[31:0]; ml = q[31:0];
        end else begin
          mh = x % y; ml = x / y;
        end
      end
    endcase
  endtask

  // Drive a request for one cycle; queue its expected result if it will complete.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit completes, output int lat);
    exp_t         e;
    logic [W-1:0] mh, ml;
    logic         md;
    model(o, x, y, mh, ml, md);
    lat = (o[1] && (y == '0)) ? 2 : LAT;
    if (completes) begin
      e.issue = cyc; e.due = cyc + lat; e.hi = mh; e.lo = ml; e.dz = md;
      sb_q.push_back(e);
      last_hi = mh; last_lo = ml; last_dz = md;
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walk an operation to its done cycle checking busy; optional ignored starts.
  task automatic track(input int lat, input bit noise);
    for (int k = 1; k <= lat; k++) begin
      if (noise && (k < lat) && ($urandom_range(7) == 0)) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("busy", 64'(busy), 64'(k < lat));
      if (k < lat) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  // Monitor: compare on every done pulse, flag missing or unexpected dones.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.due));
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        check("div_zero", 64'(div_zero), 64'(mon_e.dz));
      end
    end else if ((sb_q.size() > 0) && (cyc > sb_q[0].due)) begin
      checks++; errors++;
      $display("FAIL missing_done actual=0 expected=1 due=%0d cycle=%0d", sb_q[0].due, cyc);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [W-1:0] x, y;
    logic [1:0]   o;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max*max
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, lat); track(lat, 0);

    // MULT -3*7 then back-to-back DIVU 7/2
    issue(MULT, 32'hFFFF_FFFD, 32'd7, 1, lat); track(lat, 0);
    issue(DIVU, 32'd7, 32'd2, 1, lat); track(lat, 0);

    // DIV -7/2 then most-negative / -1
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 1, lat); track(lat, 0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat); track(lat, 0);

    // Divide by zero then MULTU clears div_zero
    issue(DIV, 32'd5, 32'd0, 1, lat); track(lat, 0);
    issue(MULTU, 32'd2, 32'd3, 1, lat); track(lat, 0);

    // Flush in CALC at cycle 10; starts in cycles 2..9 ignored
    issue(MULT, $urandom, $urandom, 0, lat);
    for (int k = 1; k <= 9; k++) begin
      start = (k >= 2);
      if (k >= 2) begin op = 2'($urandom); a = $urandom; b = $urandom; end
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("busy_c10", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'(last_hi));
    check("flush_lo", 64'(lo), 64'(last_lo));
    issue(MULTU, $urandom, $urandom, 1, lat); track(lat, 1);

    // Flush in FIX
    issue(DIVU, $urandom, $urandom | 32'd1, 0, lat);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fixflush_busy", 64'(busy), 64'd0);
    check("fixflush_hi", 64'(hi), 64'(last_hi));
    check("fixflush_lo", 64'(lo), 64'(last_lo));
    check("fixflush_dz", 64'(div_zero), 64'(last_dz));

    // Flush in IDLE drops a same-cycle start
    start = 1'b1; flush = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idleflush_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // Randomized operations with corner-case operand bias
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(9))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(100)); y = 32'($urandom_range(9)); end
        3: y = 32'($urandom_range(1, 15)) | {W{y[W-1]}} & 32'hFFFF_FFF0;
        default: ;
      endcase
      issue(o, x, y, 1, lat);
      track(lat, 1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    // Reset mid-DIVU after a divide by zero left div_zero set
    issue(DIV, 32'd9, 32'd0, 1, lat); track(lat, 0);
    issue(DIVU, $urandom, $urandom | 32'd1, 0, lat);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    check("mrst_dz", 64'(div_zero), 64'd0);
    repeat (40) @(negedge clk);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
